// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the instruction and data ports.
// Latency: request sampled at E0, ack pulse set at E0+MEM_LATENCY+1; one access per MEM_LATENCY+3 cycles.
// Backpressure: requests are held by the requester until its ack; no arbitration while busy.
// Optional feature: define MEM_ARB_RR_EN for round-robin on ties (default: data port always wins).
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  im_req,
    input  logic [ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0] im_rdata,
    output logic                  im_ack,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter start value; legal latencies 1..15 fit in four bits.
    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       op_we;      // current access is a data write
    logic       any_req;
    logic       pick_dm;    // data port wins the arbitration this cycle

    assign any_req = im_req | dm_req;

`ifdef MEM_ARB_RR_EN
    logic last_dm;          // 1 = data port was granted last

    // On a tie the port not granted last wins; instruction-last at reset.
    always_comb begin
        pick_dm = dm_req & (~im_req | ~last_dm);
    end

    // Remember who won each arbitration.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_dm <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_dm <= pick_dm;
        end
    end
`else
    // Fixed priority: data port over instruction port.
    always_comb begin
        pick_dm = dm_req;
    end
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE arbitrates, WAIT counts down, DONE holds the ack for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered memory bus, grant, ack and read-data capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            op_we     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            im_rdata  <= '0;
            dm_rdata  <= '0;
            im_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_en    <= 1'b1;
                        mem_we    <= pick_dm & dm_we;
                        op_we     <= pick_dm & dm_we;
                        mem_addr  <= pick_dm ? dm_addr : im_addr;
                        mem_wdata <= pick_dm ? dm_wdata : '0;
                        grant     <= pick_dm ? 2'b10 : 2'b01;
                        cnt       <= LAT_INIT;
                        busy      <= 1'b1;
                    end
                end
                WAIT: begin
                    // The strobe lasts only the first WAIT cycle.
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (cnt == 4'd0) begin
                        if (grant[1]) begin
                            dm_ack <= 1'b1;
                            if (!op_we) dm_rdata <= mem_rdata;
                        end else begin
                            im_ack   <= 1'b1;
                            im_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    im_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    grant  <= 2'b00;
                    busy   <= 1'b0;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with MEM_LATENCY=1 (dut) and MEM_LATENCY=3 (dut_l3).
// Each instance drives its own memory model with the matching read latency.
// Expected results are queued when a request is issued and compared when its ack appears.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        im_req    [2];
    logic [11:0] im_addr   [2];
    logic [31:0] im_rdata  [2];
    logic        im_ack    [2];
    logic        dm_req    [2];
    logic        dm_we     [2];
    logic [11:0] dm_addr   [2];
    logic [31:0] dm_wdata  [2];
    logic [31:0] dm_rdata  [2];
    logic        dm_ack    [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [11:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [1:0]  grant     [2];
    logic        busy      [2];

    mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .im_req(im_req[0]), .im_addr(im_addr[0]), .im_rdata(im_rdata[0]), .im_ack(im_ack[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_rdata(dm_rdata[0]), .dm_ack(dm_ack[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .grant(grant[0]), .busy(busy[0])
    );

    mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_l3 (
        .clock(clock), .reset(reset),
        .im_req(im_req[1]), .im_addr(im_addr[1]), .im_rdata(im_rdata[1]), .im_ack(im_ack[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_rdata(dm_rdata[1]), .dm_ack(dm_ack[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .grant(grant[1]), .busy(busy[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory models ----------------
    logic [31:0] mem  [2][256];
    logic [31:0] pipe [2][3];

    function automatic logic [31:0] init_word(input int k, input int i);
        if (i == 16) return 32'hDEADBEEF;
        return {8'hA5, 8'(k), 8'h00, 8'(i)};
    endfunction

    // Read data appears MEM_LATENCY edges after the strobe; garbage when no read was issued.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= init_word(k, i);
            end else if (mem_en[k] && mem_we[k]) begin
                mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
            end
            pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem[k][mem_addr[k][7:0]] : 32'hBADBAD00;
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end
    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          inst;
        logic        dm;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_dm_last = 32'h0;

    task automatic push(input int k, input logic dm, input logic [31:0] d);
        exp_t e;
        e.inst = k;
        e.dm   = dm;
        e.data = d;
        sb.push_back(e);
    endtask

    // Scoreboard pop on every ack, plus strobe protocol checks.
    logic prev_en [2] = '{1'b0, 1'b0};
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (im_ack[k] || dm_ack[k]) begin
                    check("ack_expected", 64'(sb.size() > 0), 64'd1);
                    check("ack_onehot", 64'(im_ack[k] & dm_ack[k]), 64'd0);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_inst", 64'(e.inst), 64'(k));
                        check("sb_port", 64'(dm_ack[k]), 64'(e.dm));
                        check("sb_rdata", dm_ack[k] ? 64'(dm_rdata[k]) : 64'(im_rdata[k]), 64'(e.data));
                    end
                end
                if (mem_we[k]) check("we_with_en", 64'(mem_en[k]), 64'd1);
                if (mem_en[k]) check("en_one_cycle", 64'(prev_en[k]), 64'd0);
                prev_en[k] = mem_en[k];
            end
        end else begin
            prev_en[0] = 1'b0;
            prev_en[1] = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_en(input int k);
        int t = 0;
        while (!mem_en[k] && t < 30) begin
            cyc(1);
            t++;
        end
        check("wait_en_timeout", 64'(mem_en[k]), 64'd1);
    endtask

    task automatic wait_ack(input int k);
        int t = 0;
        while (!(im_ack[k] || dm_ack[k]) && t < 30) begin
            cyc(1);
            t++;
        end
        check("wait_ack_timeout", 64'(im_ack[k] | dm_ack[k]), 64'd1);
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_mem_en"},   64'(mem_en[k]),    64'd0);
        check({tag, "_mem_we"},   64'(mem_we[k]),    64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr[k]),  64'd0);
        check({tag, "_mem_wdat"}, 64'(mem_wdata[k]), 64'd0);
        check({tag, "_im_rdata"}, 64'(im_rdata[k]),  64'd0);
        check({tag, "_dm_rdata"}, 64'(dm_rdata[k]),  64'd0);
        check({tag, "_acks"},     64'({im_ack[k], dm_ack[k]}), 64'd0);
        check({tag, "_grant"},    64'(grant[k]),     64'd0);
        check({tag, "_busy"},     64'(busy[k]),      64'd0);
    endtask

    // Global bound on the whole run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic exp_dm;
        logic saw_ack;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            im_req[k] = 1'b0; im_addr[k] = '0;
            dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0;
        end
        cyc(2);
        check_zero(0, "reset");
        reset = 1'b0;
        cyc(1);

        // Single instruction read, MEM_LATENCY=1.
        im_addr[0] = 12'h010;
        im_req[0]  = 1'b1;
        push(0, 1'b0, 32'hDEADBEEF);
        cyc(1);
        check("im_en_E0",    64'(mem_en[0]),   64'd1);
        check("im_addr_E0",  64'(mem_addr[0]), 64'h010);
        check("im_we_E0",    64'(mem_we[0]),   64'd0);
        check("im_grant_E0", 64'(grant[0]),    64'b01);
        check("im_busy_E0",  64'(busy[0]),     64'd1);
        cyc(1);
        check("im_en_E1",    64'(mem_en[0]),   64'd0);
        check("im_ack_E1",   64'(im_ack[0]),   64'd0);
        cyc(1);
        check("im_ack_E2",   64'(im_ack[0]),   64'd1);
        check("im_rdata_E2", 64'(im_rdata[0]), 64'hDEADBEEF);
        im_req[0] = 1'b0;
        cyc(1);
        check("im_ack_E3",   64'(im_ack[0]),   64'd0);
        check("im_grant_E3", 64'(grant[0]),    64'd0);
        check("im_busy_E3",  64'(busy[0]),     64'd0);

        // Simultaneous requests: data port first, instruction port next.
        im_addr[0] = 12'h011;
        dm_addr[0] = 12'h021;
        dm_we[0]   = 1'b0;
        push(0, 1'b1, mem[0][33]);
        push(0, 1'b0, mem[0][17]);
        exp_dm_last = mem[0][33];
        im_req[0] = 1'b1;
        dm_req[0] = 1'b1;
        cyc(1);
        check("sim_grant_E0", 64'(grant[0]),    64'b10);
        check("sim_addr_E0",  64'(mem_addr[0]), 64'h021);
        cyc(2);
        check("sim_dm_ack_E2", 64'(dm_ack[0]), 64'd1);
        dm_req[0] = 1'b0;
        cyc(1);
        check("sim_grant_E3", 64'(grant[0]),    64'b00);
        cyc(1);
        check("sim_grant_E4", 64'(grant[0]),    64'b01);
        check("sim_addr_E4",  64'(mem_addr[0]), 64'h011);
        cyc(2);
        check("sim_im_ack_E6", 64'(im_ack[0]), 64'd1);
        im_req[0] = 1'b0;
        cyc(2);

        // Continuous contention: both requests held high across four accesses.
        im_addr[0] = 12'h012;
        dm_addr[0] = 12'h022;
        im_req[0]  = 1'b1;
        dm_req[0]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_dm = (i % 2 == 0);
`else
            exp_dm = 1'b1;
`endif
            push(0, exp_dm, exp_dm ? mem[0][34] : mem[0][18]);
            if (exp_dm) exp_dm_last = mem[0][34];
            wait_en(0);
            check("cont_grant", 64'(grant[0]), exp_dm ? 64'b10 : 64'b01);
            wait_ack(0);
            if (i == 3) begin
                im_req[0] = 1'b0;
                dm_req[0] = 1'b0;
            end
        end
        cyc(2);

        // Data write: same timing as a read, dm_rdata untouched.
        dm_addr[0]  = 12'h020;
        dm_wdata[0] = 32'h12345678;
        dm_we[0]    = 1'b1;
        dm_req[0]   = 1'b1;
        push(0, 1'b1, exp_dm_last);
        cyc(1);
        check("wr_en_E0",    64'(mem_en[0]),    64'd1);
        check("wr_we_E0",    64'(mem_we[0]),    64'd1);
        check("wr_addr_E0",  64'(mem_addr[0]),  64'h020);
        check("wr_wdata_E0", 64'(mem_wdata[0]), 64'h12345678);
        cyc(1);
        check("wr_we_E1",    64'(mem_we[0]),    64'd0);
        cyc(1);
        check("wr_ack_E2",   64'(dm_ack[0]),    64'd1);
        check("wr_rdata_E2", 64'(dm_rdata[0]),  64'(exp_dm_last));
        dm_req[0] = 1'b0;
        dm_we[0]  = 1'b0;
        cyc(2);

        // Read back the written word.
        push(0, 1'b1, 32'h12345678);
        dm_req[0] = 1'b1;
        wait_ack(0);
        dm_req[0] = 1'b0;
        cyc(2);

        // Long latency, MEM_LATENCY=3: ack at E4, busy E0..E5.
        im_addr[1] = 12'h030;
        push(1, 1'b0, mem[1][48]);
        im_req[1] = 1'b1;
        cyc(1);
        check("l3_busy_E0", 64'(busy[1]),   64'd1);
        check("l3_en_E0",   64'(mem_en[1]), 64'd1);
        cyc(3);
        check("l3_ack_E3",  64'(im_ack[1]), 64'd0);
        check("l3_busy_E3", 64'(busy[1]),   64'd1);
        cyc(1);
        check("l3_ack_E4",  64'(im_ack[1]), 64'd1);
        check("l3_busy_E4", 64'(busy[1]),   64'd1);
        im_req[1] = 1'b0;
        cyc(1);
        check("l3_ack_E5",  64'(im_ack[1]), 64'd0);
        check("l3_busy_E5", 64'(busy[1]),   64'd0);
        cyc(1);

        // Reset in the middle of WAIT drops the access with no ack.
        dm_addr[1] = 12'h031;
        dm_req[1]  = 1'b1;
        cyc(2);
        check("rst_busy_pre", 64'(busy[1]), 64'd1);
        reset = 1'b1;
        cyc(1);
        check_zero(1, "rst_mid");
        dm_req[1] = 1'b0;
        reset     = 1'b0;
        saw_ack   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            saw_ack = saw_ack | dm_ack[1] | im_ack[1];
        end
        check("rst_no_ack", 64'(saw_ack), 64'd0);
        check("rst_busy_post", 64'(busy[1]), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one synchronous single-port memory between the instruction-fetch port and the data-memory port of the multi-cycle core. The core has separate `do_im_read` and `do_dm_read`/`do_dm_write` strobes. The block serialises those requests onto one memory bus with a configurable number of wait states, and returns read data with a one-cycle acknowledge per port. It sits between the controller/datapath and the memory macro.

## Interface
- `ADDR_WIDTH`, default 12: word address width.
- `DATA_WIDTH`, default 32: data width.
- `MEM_LATENCY`, default 1: edges from the memory sampling `mem_en` to `mem_rdata` being valid. Legal range is 1..15.

- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `im_req`  in  1  instruction read request; held until `im_ack`.
- `im_addr`  in  ADDR_WIDTH  instruction address; stable while `im_req` is high.
- `im_rdata`  out  DATA_WIDTH  instruction read data; valid while `im_ack` is high, held until the next `im_ack`.
- `im_ack`  out  1  one-cycle completion pulse for the instruction port.
- `dm_req`  in  1  data request; held until `dm_ack`.
- `dm_we`  in  1  1 = write, 0 = read; stable while `dm_req` is high.
- `dm_addr`  in  ADDR_WIDTH  data address.
- `dm_wdata`  in  DATA_WIDTH  write data.
- `dm_rdata`  out  DATA_WIDTH  data read result; held until the next data read completes.
- `dm_ack`  out  1  one-cycle completion pulse for the data port.
- `mem_en`  out  1  memory access strobe; high exactly one cycle per access.
- `mem_we`  out  1  memory write enable; high only together with `mem_en`.
- `mem_addr`  out  ADDR_WIDTH  memory address, registered.
- `mem_wdata`  out  DATA_WIDTH  memory write data, registered.
- `mem_rdata`  in  DATA_WIDTH  memory read data.
- `grant`  out  2  one-hot owner: bit0 = instruction port, bit1 = data port; 00 when idle.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- **IDLE:**
  - If any request is high at an edge, the winner is chosen and `grant` is set.
  - At the same edge, `mem_en`=1, `mem_addr` and `mem_wdata` are loaded from the winner, and `mem_we`=`dm_we` if the data port won, else 0.
  - The 4-bit latency counter is loaded with `MEM_LATENCY`, and the state moves to WAIT.
- **WAIT:**
  - `mem_en` and `mem_we` drop after the first cycle.
  - The counter decrements once per edge.
  - At the edge where the counter reaches 0:
    - For a read, `mem_rdata` is captured into the winner's rdata register.
    - The winner's ack is set, and the state moves to DONE.
- **DONE:**
  - The ack is high for this one cycle. No arbitration takes place in DONE, so a requester may drop `req` at the following edge.
  - At the next edge, ack and `grant` clear and the state returns to IDLE.
- **Default arbitration:** fixed priority, data port over instruction port.
- **Writes:** `dm_rdata` is not modified, and the write uses the same timing as a read.
- The instruction port has no write path; `mem_we` is never high under an instruction grant.
- **Reset at any time:**
  - State returns to IDLE and the counter is cleared.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `im_rdata`, `dm_rdata`, `im_ack`, `dm_ack`, `grant` and `busy` all go to 0.
  - Any in-flight access is dropped with no ack.
- A request that is deasserted before its ack is a protocol violation; the access still completes and acks.

## Timing
- A request is sampled at edge E0.
- `mem_en` is high in the cycle E0..E1, and the memory samples it at E1.
- The ack is set at edge E0+MEM_LATENCY+1 and is high for exactly one cycle.
- DONE occupies one cycle, then one cycle in IDLE follows before the next sample edge.
- Back-to-back throughput is one access per MEM_LATENCY+3 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration using a 1-bit last-granted register; on simultaneous requests, the port not granted last wins.
  - The register resets to "instruction last", so the data port wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed data-over-instruction priority, and the last-granted register is not present.

## Test plan
- **Reset:** assert reset mid-WAIT with MEM_LATENCY=3 -> all outputs 0 next cycle; no ack ever appears for the dropped access; `busy`=0.
- **Single instruction read:** MEM_LATENCY=1, `im_req` with `im_addr`=0x010, memory returns 0xDEADBEEF -> `mem_en`=1 and `mem_addr`=0x010 for one cycle after E0; `im_ack` high after E2 with `im_rdata`=0xDEADBEEF.
- **Data write:** `dm_we`=1, `dm_addr`=0x020, `dm_wdata`=0x12345678 -> `mem_en`=`mem_we`=1 for one cycle with that address and data; `dm_ack` after E2; `dm_rdata` unchanged.
- **Simultaneous requests, fixed priority:** both requests at E0, MEM_LATENCY=1 -> `grant`=10 and `dm_ack` after E2; `grant`=01 at E4 and `im_ack` after E6.
- **Continuous contention with `MEM_ARB_RR_EN`:** both requests held high continuously -> grants alternate dm, im, dm, im; without the macro, dm wins every tie.
- **Long latency:** MEM_LATENCY=3 -> ack rises at E4; `busy` high from E0 to E5.
